// File: rtl/led_sched_pkg.sv
// Shared types and sizing helpers for the LED blink-code scheduler.
// Optional round-robin arbitration is enabled with `define LED_SCHED_RR_EN (see led_blink_scheduler).
package led_sched_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOn   = 2'd1,
    StOff  = 2'd2,
    StGap  = 2'd3
  } led_state_e;

  // Clock cycles per phase tick; never below 2 so the prescaler always has a wrap cycle.
  function automatic int unsigned calc_tick_div(input int unsigned clk_hz,
                                                input int unsigned tick_hz);
    int unsigned div;
    div = clk_hz / tick_hz;
    return (div < 2) ? 2 : div;
  endfunction

  function automatic int unsigned calc_cnt_w(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned calc_phase_w(input int unsigned on_ticks,
                                               input int unsigned off_ticks,
                                               input int unsigned gap_ticks);
    int unsigned m;
    m = on_ticks;
    if (off_ticks > m) m = off_ticks;
    if (gap_ticks > m) m = gap_ticks;
    return calc_cnt_w(m);
  endfunction

endpackage

// File: rtl/led_tick_prescaler.sv
// Free-running tick prescaler: counts 0..TickDiv-1 and pulses tick_o on the wrap cycle.
// Held at zero while clear_i is high, so the first phase after release lasts whole ticks.
module led_tick_prescaler #(
  parameter int unsigned TickDiv = 10
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  output logic tick_o
);

  localparam int unsigned CntW = $clog2(TickDiv);
  localparam logic [CntW-1:0] CntMax = CntW'(TickDiv - 1);

  logic [CntW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d  = cnt_q;
    tick_o = 1'b0;
    if (clear_i) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      cnt_d  = '0;
      tick_o = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_blink_scheduler.sv
// Shares one LED between NUM_REQ requesters, each playing an N-pulse blink code.
// Fixed priority by default; `define LED_SCHED_RR_EN selects round-robin arbitration.
module led_blink_scheduler
  import led_sched_pkg::*;
#(
  parameter int unsigned CLK_HZ    = 100000000,
  parameter int unsigned TICK_HZ   = 10,
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned CODE_W    = 4,
  parameter int unsigned ON_TICKS  = 2,
  parameter int unsigned OFF_TICKS = 2,
  parameter int unsigned GAP_TICKS = 6
) (
  input  logic                        CLK100MHZ,
  input  logic                        CPU_RESETN,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*CODE_W-1:0]   req_code,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        busy,
  output logic                        LED
);

  localparam int unsigned TickDiv = calc_tick_div(CLK_HZ, TICK_HZ);
  localparam int unsigned PhaseW  = calc_phase_w(ON_TICKS, OFF_TICKS, GAP_TICKS);
  localparam int unsigned IdW     = $clog2(NUM_REQ);

  localparam logic [PhaseW-1:0] OnLast  = PhaseW'(ON_TICKS - 1);
  localparam logic [PhaseW-1:0] OffLast = PhaseW'(OFF_TICKS - 1);
  localparam logic [PhaseW-1:0] GapLast = PhaseW'(GAP_TICKS - 1);

  led_state_e        state_d, state_q;
  logic [PhaseW-1:0] phase_d, phase_q;
  logic [CODE_W-1:0] pulse_d, pulse_q;
  logic [IdW-1:0]    grant_d, grant_q;
  logic              led_d, led_q;

  logic              tick;
  logic              presc_clear;
  logic              sel_valid;
  logic [IdW-1:0]    sel_idx;
  logic [CODE_W-1:0] sel_code;
  logic              accept;

  assign presc_clear = (state_q == StIdle);

  led_tick_prescaler #(
    .TickDiv (TickDiv)
  ) u_prescaler (
    .clk_i   (CLK100MHZ),
    .rst_ni  (CPU_RESETN),
    .clear_i (presc_clear),
    .tick_o  (tick)
  );

`ifdef LED_SCHED_RR_EN
  logic [IdW-1:0] rr_ptr_d, rr_ptr_q;
  int             cand;

  // Scan offsets high to low so the smallest offset from the pointer wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = int'(rr_ptr_q) + k;
      if (cand >= int'(NUM_REQ)) cand = cand - int'(NUM_REQ);
      if (req_valid[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = IdW'(cand);
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept) begin
      rr_ptr_d = (sel_idx == IdW'(NUM_REQ - 1)) ? '0 : sel_idx + 1'b1;
    end
  end

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      rr_ptr_q <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end
`else
  // Scan high to low so the lowest valid index wins.
  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        sel_valid = 1'b1;
        sel_idx   = IdW'(i);
      end
    end
  end
`endif

  assign sel_code = req_code[sel_idx*CODE_W +: CODE_W];

  always_comb begin
    req_ready = '0;
    if ((state_q == StIdle) && sel_valid) begin
      req_ready[sel_idx] = 1'b1;
    end
  end

  assign accept = |(req_ready & req_valid);

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    pulse_d = pulse_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          grant_d = sel_idx;
          // A zero code is consumed without lighting the LED.
          if (sel_code != '0) begin
            pulse_d = sel_code;
            phase_d = '0;
            state_d = StOn;
          end
        end
      end
      StOn: begin
        if (tick) begin
          if (phase_q == OnLast) begin
            phase_d = '0;
            pulse_d = pulse_q - 1'b1;
            state_d = (pulse_q == CODE_W'(1)) ? StGap : StOff;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      StOff: begin
        if (tick) begin
          if (phase_q == OffLast) begin
            phase_d = '0;
            state_d = StOn;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      StGap: begin
        if (tick) begin
          if (phase_q == GapLast) begin
            phase_d = '0;
            state_d = StIdle;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign led_d = (state_d == StOn);

  always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
    if (!CPU_RESETN) begin
      state_q <= StIdle;
      phase_q <= '0;
      pulse_q <= '0;
      grant_q <= '0;
      led_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      pulse_q <= pulse_d;
      grant_q <= grant_d;
      led_q   <= led_d;
    end
  end

  assign grant_id = grant_q;
  assign busy     = (state_q != StIdle);
  assign LED      = led_q;

endmodule

// File: tb/tb_led_blink_scheduler.sv
// Scoreboard bench for led_blink_scheduler: expected grants are queued as requests are driven
// and checked, with the LED waveform, as the scheduler accepts and plays each code.
module tb_led_blink_scheduler;

  localparam int NReq    = 4;
  localparam int CodeW   = 4;
  localparam int OnT     = 2;
  localparam int OffT    = 2;
  localparam int GapT    = 4;
  localparam int TickDiv = 10;

  logic                    CLK100MHZ = 1'b0;
  logic                    CPU_RESETN = 1'b0;
  logic [NReq-1:0]         req_valid = '0;
  logic [NReq*CodeW-1:0]   req_code = '0;
  logic [NReq-1:0]         req_ready;
  logic [1:0]              grant_id;
  logic                    busy;
  logic                    LED;

  led_blink_scheduler #(
    .CLK_HZ    (100),
    .TICK_HZ   (10),
    .NUM_REQ   (NReq),
    .CODE_W    (CodeW),
    .ON_TICKS  (OnT),
    .OFF_TICKS (OffT),
    .GAP_TICKS (GapT)
  ) dut (
    .CLK100MHZ  (CLK100MHZ),
    .CPU_RESETN (CPU_RESETN),
    .req_valid  (req_valid),
    .req_code   (req_code),
    .req_ready  (req_ready),
    .grant_id   (grant_id),
    .busy       (busy),
    .LED        (LED)
  );

  always #5 CLK100MHZ = ~CLK100MHZ;

  typedef struct {
    int id;
    int code;
  } grant_t;

  grant_t exp_q[$];
  int     checks = 0;
  int     errors = 0;
  bit     mon_en = 1'b0;
  bit     playing = 1'b0;
  int     play_k, play_n, play_dur;
  bit     gid_pend = 1'b0;
  int     gid_exp;
  int     model_ptr = 0;
  int     accepts = 0;
  int     base;

  task automatic check_eq(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // LED level k cycles after the accept edge for an n-pulse code.
  function automatic int exp_led(input int k, input int n);
    int t;
    t = (k - 1) / TickDiv;
    if (t < n * OnT + (n - 1) * OffT) return ((t % (OnT + OffT)) < OnT) ? 1 : 0;
    return 0;
  endfunction

  function automatic logic [NReq-1:0] model_ready(input logic [NReq-1:0] v, input int ptr);
    logic [NReq-1:0] r;
    int c;
    r = '0;
    for (int k = 0; k < NReq; k++) begin
`ifdef LED_SCHED_RR_EN
      c = (ptr + k) % NReq;
`else
      c = k + 0 * ptr;
`endif
      if (v[c]) begin
        r[c] = 1'b1;
        return r;
      end
    end
    return r;
  endfunction

  task automatic monitor();
    grant_t e;
    int idx;
    logic [NReq-1:0] acc;
    forever begin
      @(negedge CLK100MHZ);
      if (!CPU_RESETN) begin
        playing   = 1'b0;
        gid_pend  = 1'b0;
        model_ptr = 0;
      end else if (mon_en) begin
        if (gid_pend) begin
          check_eq("grant_id", int'(grant_id), gid_exp);
          gid_pend = 1'b0;
        end
        if (playing) begin
          play_k++;
          if (play_k <= play_dur) begin
            check_eq("led", int'(LED), exp_led(play_k, play_n));
            check_eq("busy", int'(busy), 1);
            check_eq("ready_busy", int'(req_ready), 0);
          end else begin
            playing = 1'b0;
          end
        end
        if (!playing) begin
          check_eq("led_idle", int'(LED), 0);
          check_eq("busy_idle", int'(busy), 0);
          check_eq("ready", int'(req_ready), int'(model_ready(req_valid, model_ptr)));
          acc = req_ready & req_valid;
          if (acc != '0) begin
            idx = 0;
            for (int i = NReq - 1; i >= 0; i--) if (acc[i]) idx = i;
            accepts++;
            check_eq("accept_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) begin
              e = exp_q.pop_front();
              check_eq("grant_order", idx, e.id);
              gid_pend  = 1'b1;
              gid_exp   = e.id;
              model_ptr = (idx + 1) % NReq;
              if (e.code > 0) begin
                playing  = 1'b1;
                play_k   = 0;
                play_n   = e.code;
                play_dur = (e.code * OnT + (e.code - 1) * OffT + GapT) * TickDiv;
              end
            end
          end
        end
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic do_reset();
    mon_en     = 1'b0;
    CPU_RESETN = 1'b0;
    req_valid  = '0;
    req_code   = '0;
    cyc(3);
    CPU_RESETN = 1'b1;
    mon_en     = 1'b1;
  endtask

  task automatic wait_accepts(input int target, input int budget);
    int n = 0;
    while (accepts < target && n < budget) begin
      cyc(1);
      n++;
    end
    check_eq("accept_timeout", int'(accepts >= target), 1);
  endtask

  task automatic wait_play(input int k, input int budget);
    int n = 0;
    while (!(playing && play_k >= k) && n < budget) begin
      cyc(1);
      n++;
    end
    check_eq("play_timeout", int'(playing && play_k >= k), 1);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || playing) && n < budget) begin
      cyc(1);
      n++;
    end
    check_eq("idle_timeout", int'(exp_q.size() == 0 && !playing), 1);
    cyc(2);
  endtask

  initial begin
    fork
      monitor();
      begin
        // Reset values and a single 3-pulse code on requester 1.
        do_reset();
        check_eq("rst_led", int'(LED), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_ready", int'(req_ready), 0);
        check_eq("rst_grant", int'(grant_id), 0);
        base = accepts;
        req_code[7:4] = 4'd3;
        exp_q.push_back('{id: 1, code: 3});
        req_valid = 4'b0010;
        wait_accepts(base + 1, 5);
        req_valid = '0;
        wait_idle(300);

`ifdef LED_SCHED_RR_EN
        // Two requesters held valid alternate under round-robin.
        do_reset();
        base = accepts;
        req_code[7:4]   = 4'd1;
        req_code[15:12] = 4'd2;
        exp_q.push_back('{id: 1, code: 1});
        exp_q.push_back('{id: 3, code: 2});
        exp_q.push_back('{id: 1, code: 1});
        exp_q.push_back('{id: 3, code: 2});
        req_valid = 4'b1010;
        wait_accepts(base + 4, 1000);
        req_valid = '0;
        wait_idle(400);
`else
        // Simultaneous requests: 1 wins, 3 is taken in the first idle cycle afterwards.
        do_reset();
        base = accepts;
        req_code[7:4]   = 4'd2;
        req_code[15:12] = 4'd5;
        exp_q.push_back('{id: 1, code: 2});
        exp_q.push_back('{id: 3, code: 5});
        req_valid = 4'b1010;
        wait_accepts(base + 1, 5);
        req_valid[1] = 1'b0;
        wait_accepts(base + 2, 300);
        req_valid = '0;
        wait_idle(400);
`endif

        // Zero code: accepted, grant_id moves to 0, LED and busy stay low.
        base = accepts;
        req_code[3:0] = 4'd0;
        exp_q.push_back('{id: 0, code: 0});
        req_valid = 4'b0001;
        wait_accepts(base + 1, 5);
        req_valid = '0;
        cyc(6);
        check_eq("zero_led", int'(LED), 0);
        check_eq("zero_busy", int'(busy), 0);

        // Reset during the second ON pulse drops the LED at once.
        do_reset();
        base = accepts;
        req_code[11:8] = 4'd3;
        exp_q.push_back('{id: 2, code: 3});
        req_valid = 4'b0100;
        wait_accepts(base + 1, 5);
        req_valid = '0;
        wait_play(45, 100);
        check_eq("pre_rst_led", int'(LED), 1);
        #2;
        CPU_RESETN = 1'b0;
        #1;
        check_eq("async_rst_led", int'(LED), 0);
        check_eq("async_rst_busy", int'(busy), 0);
        check_eq("async_rst_grant", int'(grant_id), 0);
        cyc(2);
        base = accepts;
        req_code[7:4] = 4'd1;
        exp_q.push_back('{id: 1, code: 1});
        req_valid  = 4'b0010;
        CPU_RESETN = 1'b1;
        wait_accepts(base + 1, 2);
        req_valid = '0;
        wait_idle(100);

        // Maximum code; withdrawing the request mid-playback changes nothing.
        do_reset();
        base = accepts;
        req_code[7:4] = 4'd15;
        exp_q.push_back('{id: 1, code: 15});
        req_valid = 4'b0010;
        wait_accepts(base + 1, 5);
        wait_play(100, 200);
        req_valid = '0;
        wait_idle(800);
        check_eq("single_accept", accepts - base, 1);
      end
      begin
        #500000;
        check_eq("watchdog", int'($time < 500000), 1);
      end
    join_any
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
